// File: rtl/mem_map_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_map_pkg
// Description : MEM-stage address map, MMIO register offsets and TCON bits.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_map_pkg;

    localparam logic [31:0] c_RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] c_MMIO_BASE   = 32'h4000_0000;

    localparam logic [31:0] c_OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] c_OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] c_OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] c_OFF_LED     = 32'h0000_000C;
    localparam logic [31:0] c_OFF_DIGI    = 32'h0000_0010;
    localparam logic [31:0] c_OFF_SYSTICK = 32'h0000_0014;

    // Word index of each register inside the 32-byte MMIO block
    localparam logic [2:0]  c_IDX_TH      = c_OFF_TH[4:2];
    localparam logic [2:0]  c_IDX_TL      = c_OFF_TL[4:2];
    localparam logic [2:0]  c_IDX_TCON    = c_OFF_TCON[4:2];
    localparam logic [2:0]  c_IDX_LED     = c_OFF_LED[4:2];
    localparam logic [2:0]  c_IDX_DIGI    = c_OFF_DIGI[4:2];
    localparam logic [2:0]  c_IDX_SYSTICK = c_OFF_SYSTICK[4:2];

    localparam int c_TCON_EN = 0;
    localparam int c_TCON_IE = 1;
    localparam int c_TCON_IS = 2;

    typedef enum logic [1:0] {
        TSEL_NONE = 2'd0,
        TSEL_TH   = 2'd1,
        TSEL_TL   = 2'd2,
        TSEL_TCON = 2'd3
    } tsel_e;

endpackage
`default_nettype wire

// File: rtl/mem_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_timer
// Description : TH/TL/TCON reload timer with interrupt; present only when
//               MEM_STAGE_TIMER_EN is defined, otherwise reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timer
    import mem_map_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  tsel_e       i_sel,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_th,
    output logic [31:0] o_tl,
    output logic [2:0]  o_tcon,
    output logic        o_irq
);

`ifdef MEM_STAGE_TIMER_EN
    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_tick;
    logic        w_wrap;

    assign w_wr_th   = i_we && (i_sel == TSEL_TH);
    assign w_wr_tl   = i_we && (i_sel == TSEL_TL);
    assign w_wr_tcon = i_we && (i_sel == TSEL_TCON);
    // A CPU write to TL or TCON cancels this cycle's count and overflow entirely
    assign w_tick    = r_tcon[c_TCON_EN] && !w_wr_tl && !w_wr_tcon;
    assign w_wrap    = (r_tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th   <= 32'h0;
            r_tl   <= 32'h0;
            r_tcon <= 3'b000;
        end else begin
            if (w_wr_th) begin
                r_th <= i_wdata;
            end
            if (w_wr_tl) begin
                r_tl <= i_wdata;
            end else if (w_tick) begin
                r_tl <= w_wrap ? r_th : r_tl + 32'd1;
            end
            if (w_wr_tcon) begin
                r_tcon <= i_wdata[2:0];
            end else if (w_tick && w_wrap && r_tcon[c_TCON_IE]) begin
                r_tcon[c_TCON_IS] <= 1'b1;
            end
        end
    end

    assign o_th   = r_th;
    assign o_tl   = r_tl;
    assign o_tcon = r_tcon;
    assign o_irq  = r_tcon[c_TCON_IE] & r_tcon[c_TCON_IS];
`else
    logic w_unused;
    assign w_unused = ^{clk, reset, i_we, i_sel, i_wdata};

    assign o_th   = 32'h0;
    assign o_tl   = 32'h0;
    assign o_tcon = 3'b000;
    assign o_irq  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS MEM stage: data RAM, MMIO decode, LED/DIGI/SYSTICK
//               registers; timer built in with MEM_STAGE_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_map_pkg::*;
#(
    parameter int RAM_DEPTH = 512,
    parameter int RAM_AW    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_wr,
    input  logic        mem_rd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic [31:0] systick
);

    logic [31:0]       r_ram [RAM_DEPTH];
    logic [7:0]        r_led;
    logic [11:0]       r_digi;
    logic [31:0]       r_systick;

    logic              w_ram_hit;
    logic              w_mmio_hit;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [2:0]        w_reg_idx;
    logic [31:0]       w_rd_val;
    tsel_e             w_tsel;
    logic              w_timer_we;
    logic [31:0]       w_th;
    logic [31:0]       w_tl;
    logic [2:0]        w_tcon;
    logic              w_irq;
    logic              w_unused;

    assign w_unused   = ^addr[1:0];
    assign w_ram_hit  = (addr[31:RAM_AW+2] == c_RAM_BASE[31:RAM_AW+2]);
    assign w_mmio_hit = (addr[31:5] == c_MMIO_BASE[31:5]);
    assign w_ram_idx  = addr[RAM_AW+1:2];
    assign w_reg_idx  = addr[4:2];

    always_comb begin
        w_tsel = TSEL_NONE;
        if (w_mmio_hit) begin
            case (w_reg_idx)
                c_IDX_TH:   w_tsel = TSEL_TH;
                c_IDX_TL:   w_tsel = TSEL_TL;
                c_IDX_TCON: w_tsel = TSEL_TCON;
                default:    w_tsel = TSEL_NONE;
            endcase
        end
    end

    assign w_timer_we = mem_wr && (w_tsel != TSEL_NONE);

    mem_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_timer_we),
        .i_sel   (w_tsel),
        .i_wdata (wdata),
        .o_th    (w_th),
        .o_tl    (w_tl),
        .o_tcon  (w_tcon),
        .o_irq   (w_irq)
    );

    // RAM has no reset; a store presented while reset is high is dropped
    always_ff @(posedge clk) begin
        if (mem_wr && w_ram_hit && !reset) begin
            r_ram[w_ram_idx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led     <= 8'h0;
            r_digi    <= 12'h0;
            r_systick <= 32'h0;
        end else begin
            r_systick <= r_systick + 32'd1;
            if (mem_wr && w_mmio_hit && (w_reg_idx == c_IDX_LED)) begin
                r_led <= wdata[7:0];
            end
            if (mem_wr && w_mmio_hit && (w_reg_idx == c_IDX_DIGI)) begin
                r_digi <= wdata[11:0];
            end
        end
    end

    always_comb begin
        w_rd_val = 32'h0;
        if (w_ram_hit) begin
            w_rd_val = r_ram[w_ram_idx];
        end else if (w_mmio_hit) begin
            case (w_reg_idx)
                c_IDX_TH:      w_rd_val = w_th;
                c_IDX_TL:      w_rd_val = w_tl;
                c_IDX_TCON:    w_rd_val = {29'd0, w_tcon};
                c_IDX_LED:     w_rd_val = {24'd0, r_led};
                c_IDX_DIGI:    w_rd_val = {20'd0, r_digi};
                c_IDX_SYSTICK: w_rd_val = r_systick;
                default:       w_rd_val = 32'h0;
            endcase
        end
    end

    assign rdata   = mem_rd ? w_rd_val : 32'h0;
    assign irq     = w_irq;
    assign led     = r_led;
    assign digi    = r_digi;
    assign systick = r_systick;

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Decodes the registered ALU result as a byte address. Performs data-RAM or memory-mapped peripheral access.
- Returns read data combinationally, so MEM/WB captures it in the same cycle.
- Owns the peripheral registers: timer, LEDs, 7-segment display and the free-running system tick counter.

Parameters:
- RAM_DEPTH, 512: number of 32-bit data-RAM words; must be a power of 2.
- RAM_AW, 9: word-address width; equals log2(RAM_DEPTH).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- mem_wr  input  1  store strobe from EX/MEM
- mem_rd  input  1  load strobe (MemtoReg==2'b01) from EX/MEM
- addr  input  32  byte address (registered ALU result)
- wdata  input  32  store data (registered rt data)
- rdata  output  32  load data, combinational
- irq  output  1  timer interrupt request to the control unit
- led  output  8  LED register
- digi  output  12  7-segment register: [11:8] anode select, [7:0] segments
- systick  output  32  cycles since reset

Behaviour:
- Address map (addr[1:0] ignored, word aligned):
  - RAM: 0x0000_0000 to 0x0000_0000 + 4*RAM_DEPTH-4, indexed by addr[RAM_AW+1:2].
  - TH 0x4000_0000, TL 0x4000_0004, TCON 0x4000_0008, LED 0x4000_000C, DIGI 0x4000_0010, SYSTICK 0x4000_0014 (read-only).
  - Any other address: reads return 0, writes ignored.
- RAM: asynchronous read, synchronous write on posedge clk when mem_wr and address in range. RAM contents are not reset.
- rdata equals the decoded read value when mem_rd=1, else 32'h0.
- mem_rd and mem_wr both high: the write occurs; rdata shows the pre-write value.
- Reset values: TH, TL, TCON, led, digi, systick = 0; irq = 0.
- systick increments by 1 every cycle and wraps 0xFFFF_FFFF to 0. Writes to it are ignored.
- Timer, TCON bits: [0] enable, [1] irq enable, [2] irq status.
- Timer count, each cycle with TCON[0]=1:
  - TL != 0xFFFF_FFFF: TL <= TL+1.
  - TL == 0xFFFF_FFFF: TL <= TH, and TCON[2] <= 1 if TCON[1]=1.
- irq = TCON[1] & TCON[2], registered state, no extra latency.
- CPU writes: TH/TL/LED/DIGI take wdata (LED takes [7:0], DIGI takes [11:0]). TCON takes wdata[2:0]; writing bit2=0 is how software clears the interrupt.
- Simultaneous events: a CPU write to TL or TCON in the same cycle as a count or overflow wins entirely. A TH write on an overflow cycle: TL reloads the old TH.
- Reset mid-operation: all registers return to reset values immediately. An in-flight store is lost.

Optional Feature:
- Macro MEM_STAGE_TIMER_EN.
- Defined: timer and irq as specified above.
- Undefined: TH/TL/TCON are not implemented; reads return 0, writes are ignored, irq is tied 0. All other behaviour is unchanged.

Decomposition:
- Shared package mem_map_pkg holds the address constants (RAM base, MMIO base, per-register offsets) and the TCON bit indices, shared with the bench and the software linker script.
- One sub-module, mem_timer: holds TH/TL/TCON, takes a write strobe, register select and data, and outputs the TH/TL/TCON values and irq.
- RAM array and address decode stay in mem_stage.

Test Plan:
- After reset: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 → rdata=0xDEADBEEF. Load 0x0000_0014 (never written) → no X on any output except rdata.
- Loads at 0x4000_0100 and 0x1000_0000 → rdata=0. Store to 0x4000_0100 → led, digi and the timer are unchanged.
- Timer reload: TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, TCON=3'b011.
  - 1 cycle later TL=0xFFFF_FFFF.
  - Next cycle TL=0xFFFF_FFFD and irq=1.
  - Write TCON=3'b011 → irq=0 the next cycle.
- Collision: write TL=0x5 in the same cycle TL would overflow → TL=0x5 and TCON[2] stays 0.
- systick reads N after N cycles from reset release. Assert reset for 1 cycle mid-count → systick, led and TL read 0.
- Build without MEM_STAGE_TIMER_EN: repeat the timer-reload scenario → rdata=0 at TH/TL/TCON and irq stays 0.
